// File: rtl/lcd_write_sequencer.sv
// 4-bit HD44780 write sequencer: power-on init, then byte writes split into two E-strobed nibbles.
// Optional macro LCD_LONG_CMD_EN: user clear/home commands (0x01..0x03) get the long settle wait.
module lcd_write_sequencer #(
  parameter int PWRUP_CYC    = 1_500_000,
  parameter int INIT_W1_CYC  = 410_000,
  parameter int INIT_W2_CYC  = 10_000,
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 24,
  parameter int NIB_GAP_CYC  = 100,
  parameter int CMD_CYC      = 4000,
  parameter int LONG_CMD_CYC = 164_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(PWRUP_CYC, INIT_W1_CYC), max2(INIT_W2_CYC, SETUP_CYC)),
                                max2(max2(E_HIGH_CYC, NIB_GAP_CYC), max2(CMD_CYC, LONG_CMD_CYC)));
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  // Counter reload values: a window of N cycles loads N-1 and exits at 0.
  localparam logic [CNT_W-1:0] C_PWRUP = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_W1    = CNT_W'(INIT_W1_CYC - 1);
  localparam logic [CNT_W-1:0] C_W2    = CNT_W'(INIT_W2_CYC - 1);
  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_EHIGH = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] C_GAP   = CNT_W'(NIB_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] C_CMD   = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_CMD_CYC - 1);

  typedef enum logic [2:0] {PWRUP, INIT_NIB, INIT_WAIT, CFG, IDLE, XFER, SETTLE} state_t;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       phase, phase_n;
  logic [1:0]       idx, idx_n;
  logic             long_q, long_n;
  logic             init_done_n, e_n, rs_n;
  logic [3:0]       data_n, lo_q;
  logic             start_xfer, nrs, nlong;
  logic [7:0]       nb;

  assign wr_ready = (state == IDLE) && init_done;
  assign busy     = (state != IDLE);
  assign lcd_rw   = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PWRUP;
      cnt       <= '0;
      phase     <= '0;
      idx       <= '0;
      long_q    <= 1'b0;
      init_done <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      phase     <= phase_n;
      idx       <= idx_n;
      long_q    <= long_n;
      init_done <= init_done_n;
      lcd_e     <= e_n;
      lcd_rs    <= rs_n;
      lcd_data  <= data_n;
    end
  end

  // Low nibble is only needed after the high nibble has been strobed.
  always_ff @(posedge clk) begin
    if (start_xfer) lo_q <= nb[3:0];
  end

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt != '0) ? cnt - 1'b1 : cnt;
    phase_n     = phase;
    idx_n       = idx;
    long_n      = long_q;
    init_done_n = init_done;
    e_n         = lcd_e;
    rs_n        = lcd_rs;
    data_n      = lcd_data;
    start_xfer  = 1'b0;
    nb          = wr_data;
    nrs         = wr_rs;
    nlong       = 1'b0;
    case (state)
      PWRUP: begin
        if (phase == 3'd0) begin
          cnt_n   = C_PWRUP;
          phase_n = 3'd1;
        end else if (cnt == '0) begin
          state_n = INIT_NIB;
          phase_n = 3'd0;
          idx_n   = 2'd0;
          cnt_n   = C_SETUP;
          data_n  = 4'h3;
          rs_n    = 1'b0;
        end
      end
      INIT_NIB: begin
        if (cnt == '0) begin
          if (phase == 3'd0) begin
            phase_n = 3'd1;
            cnt_n   = C_EHIGH;
            e_n     = 1'b1;
          end else begin
            e_n     = 1'b0;
            state_n = INIT_WAIT;
            cnt_n   = (idx == 2'd0) ? C_W1 : (idx == 2'd1) ? C_W2 : C_CMD;
          end
        end
      end
      INIT_WAIT: begin
        if (cnt == '0) begin
          if (idx == 2'd3) begin
            state_n = CFG;
            idx_n   = 2'd0;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = INIT_NIB;
            phase_n = 3'd0;
            cnt_n   = C_SETUP;
            data_n  = (idx == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      CFG: begin
        start_xfer = 1'b1;
        nb         = cfg_byte(idx);
        nrs        = 1'b0;
        nlong      = (idx == 2'd3);
      end
      IDLE: begin
        if (wr_valid && wr_ready) begin
          start_xfer = 1'b1;
`ifdef LCD_LONG_CMD_EN
          nlong = !wr_rs && (wr_data inside {8'h01, 8'h02, 8'h03});
`else
          nlong = 1'b0;
`endif
        end
      end
      XFER: begin
        if (cnt == '0) begin
          phase_n = phase + 3'd1;
          case (phase)
            3'd0: begin cnt_n = C_EHIGH; e_n = 1'b1; end
            3'd1: begin cnt_n = C_GAP;   e_n = 1'b0; end
            3'd2: begin cnt_n = C_SETUP; data_n = lo_q; end
            3'd3: begin cnt_n = C_EHIGH; e_n = 1'b1; end
            default: begin
              e_n     = 1'b0;
              state_n = SETTLE;
              cnt_n   = long_q ? C_LONG : C_CMD;
            end
          endcase
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          if (init_done) begin
            state_n = IDLE;
          end else if (idx == 2'd3) begin
            state_n     = IDLE;
            init_done_n = 1'b1;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = CFG;
          end
        end
      end
      default: state_n = PWRUP;
    endcase
    // Every byte transfer starts with rs/high nibble presented while E is low.
    if (start_xfer) begin
      state_n = XFER;
      phase_n = 3'd0;
      cnt_n   = C_SETUP;
      data_n  = nb[7:4];
      rs_n    = nrs;
      e_n     = 1'b0;
      long_n  = nlong;
    end
  end

endmodule
